// File: rtl/demux_pkg.sv
// demux_pkg -- shared definitions for the stream demultiplexer.
//   mode_e     : routing mode carried on the 2-bit mode input
//   N_CH_MIN/N_CH_MAX : supported range for the channel count
//   sel_width  : width of a channel select / pointer for n channels
package demux_pkg;

  typedef enum logic [1:0] {
    DIRECT      = 2'b00,
    ROUND_ROBIN = 2'b01,
    BROADCAST   = 2'b10,
    RSVD        = 2'b11
  } mode_e;

  localparam int N_CH_MIN = 2;
  localparam int N_CH_MAX = 16;

  // A select is never narrower than one bit, even for two channels.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_stream_if.sv
// demux_stream_if -- bundles the upstream stream, per-channel downstream
// streams and the status/control sideband of demux_stream.
//   master : the environment (drives in_*, mode, out_ready, clr_err)
//   slave  : the demultiplexer (drives in_ready, out_*, sel_err, rr_ptr)
interface demux_stream_if #(
  parameter int N_CH = 8,
  parameter int DW   = 8
) ();
  localparam int SELW = demux_pkg::sel_width(N_CH);

  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic [SELW-1:0]      in_sel;
  logic [1:0]           mode;
  logic [N_CH-1:0]      out_valid;
  logic [N_CH-1:0]      out_ready;
  logic [N_CH*DW-1:0]   out_data;
  logic                 sel_err;
  logic                 clr_err;
  logic [SELW-1:0]      rr_ptr;

  modport master (
    output in_valid, in_data, in_sel, mode, out_ready, clr_err,
    input  in_ready, out_valid, out_data, sel_err, rr_ptr
  );

  modport slave (
    input  in_valid, in_data, in_sel, mode, out_ready, clr_err,
    output in_ready, out_valid, out_data, sel_err, rr_ptr
  );
endinterface

// File: rtl/demux_ch_reg.sv
// demux_ch_reg -- one-entry output register for a single channel.
//   clk, rst_n          : clock and (already synchronised) async active-low reset
//   load, load_data     : write a new word (only asserted when the slot is open)
//   out_ready           : downstream accept
//   out_valid, out_data : registered channel output
module demux_ch_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          valid_reg;
  logic [DW-1:0] data_reg;

  // A load wins over a pop, so pop+push in one cycle keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/demux_stream.sv
// demux_stream -- routes one upstream stream to N_CH registered channels in
// DIRECT, ROUND_ROBIN or BROADCAST mode (reserved mode acts as DIRECT).
//   clk, rst_n : clock, asynchronous active-low reset (release synchronised)
//   bus        : demux_stream_if slave port (stream, channels, status)
module demux_stream import demux_pkg::*; #(
  parameter int N_CH = 8,
  parameter int DW   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  demux_stream_if.slave  bus
);

  localparam int SELW = sel_width(N_CH);
  localparam int SELN = 1 << SELW;

  // Reset asserts immediately, deasserts two clocks after rst_n rises.
  logic [1:0] rst_sync_reg;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  mode_e               mode_val;
  logic [N_CH-1:0]     ch_valid;
  logic [N_CH*DW-1:0]  ch_data;
  logic [N_CH-1:0]     open;
  logic [N_CH-1:0]     load;
  logic [SELN-1:0]     open_ext;
  logic                sel_oob;
  logic                direct_like;
  logic                in_ready_c;
  logic                xfer;
  logic [SELW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic                sel_err_reg, sel_err_next;

  assign mode_val    = mode_e'(bus.mode);
  assign direct_like = (mode_val != ROUND_ROBIN) && (mode_val != BROADCAST);
  assign open        = ~ch_valid | bus.out_ready;
  assign sel_oob     = ({1'b0, bus.in_sel} >= (SELW+1)'(N_CH));

  // Pad to the full select range so any in_sel indexes a real bit.
  always_comb begin
    open_ext           = '0;
    open_ext[N_CH-1:0] = open;
  end

  // Out-of-range direct selects are accepted and dropped.
  always_comb begin
    in_ready_c = 1'b0;
    case (mode_val)
      ROUND_ROBIN: in_ready_c = open_ext[rr_ptr_reg];
      BROADCAST:   in_ready_c = &open;
      default:     in_ready_c = sel_oob ? 1'b1 : open_ext[bus.in_sel];
    endcase
  end

  assign xfer = bus.in_valid & in_ready_c;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      always_comb begin
        load[gi] = 1'b0;
        case (mode_val)
          ROUND_ROBIN: load[gi] = xfer && (rr_ptr_reg == SELW'(gi));
          BROADCAST:   load[gi] = xfer;
          default:     load[gi] = xfer && !sel_oob && (bus.in_sel == SELW'(gi));
        endcase
      end

      demux_ch_reg #(.DW(DW)) u_ch (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .load      (load[gi]),
        .load_data (bus.in_data),
        .out_ready (bus.out_ready[gi]),
        .out_valid (ch_valid[gi]),
        .out_data  (ch_data[gi*DW +: DW])
      );
    end
  endgenerate

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (xfer && (mode_val == ROUND_ROBIN))
      rr_ptr_next = (rr_ptr_reg == SELW'(N_CH-1)) ? '0 : rr_ptr_reg + SELW'(1);
  end

  // A new error takes priority over a simultaneous clear.
  always_comb begin
    sel_err_next = sel_err_reg;
    if (xfer && direct_like && sel_oob) sel_err_next = 1'b1;
    else if (bus.clr_err)               sel_err_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rr_ptr_reg  <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      rr_ptr_reg  <= rr_ptr_next;
      sel_err_reg <= sel_err_next;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = ch_valid;
  assign bus.out_data  = ch_data;
  assign bus.rr_ptr    = rr_ptr_reg;
  assign bus.sel_err   = sel_err_reg;

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream -- table vectors and hand sequences on an 8-channel
// instance, error handling and randomized model checking on a 6-channel one.
module tb_demux_stream;
  import demux_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  demux_stream_if #(.N_CH(8), .DW(8)) bus8 ();
  demux_stream_if #(.N_CH(6), .DW(8)) bus6 ();

  demux_stream #(.N_CH(8), .DW(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  demux_stream #(.N_CH(6), .DW(8)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       vld;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] ordy;
    logic       exp_rdy;
    logic [7:0] exp_ov;
    logic [2:0] chk_ch;
    logic [7:0] exp_d;
    logic [2:0] exp_ptr;
    logic       chk_d;
  } vec_t;

  vec_t tbl [13];

  // Reference model for the 6-channel instance.
  bit       m_vld [6];
  bit [7:0] m_dat [6];
  int       m_ptr;
  bit       m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] d8(input int k);
    return bus8.out_data[k*8 +: 8];
  endfunction

  function automatic logic [7:0] d6(input int k);
    return bus6.out_data[k*8 +: 8];
  endfunction

  task automatic idle_all();
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_sel = '0; bus8.mode = DIRECT;
    bus8.out_ready = '1;  bus8.clr_err = 1'b0;
    bus6.in_valid = 1'b0; bus6.in_data = '0; bus6.in_sel = '0; bus6.mode = DIRECT;
    bus6.out_ready = '1;  bus6.clr_err = 1'b0;
  endtask

  task automatic drive8(input logic [1:0] md, input logic v, input logic [2:0] s,
                        input logic [7:0] d, input logic [7:0] r);
    @(negedge clk);
    bus8.mode = md; bus8.in_valid = v; bus8.in_sel = s; bus8.in_data = d; bus8.out_ready = r;
  endtask

  task automatic drive6(input logic [1:0] md, input logic v, input logic [2:0] s,
                        input logic [7:0] d, input logic c);
    @(negedge clk);
    bus6.mode = md; bus6.in_valid = v; bus6.in_sel = s; bus6.in_data = d; bus6.clr_err = c;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus8.out_valid, 64'h0);
    chk("reset_out_data", bus8.out_data, 64'h0);
    chk("reset_rr_ptr", bus8.rr_ptr, 64'h0);
    chk("reset_sel_err", bus6.sel_err, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Direct to 0,5,7 then nine round-robin words, then an idle cycle.
    tbl[0] = '{2'd0, 1'b1, 3'd0, 8'h11, 8'hFF, 1'b1, 8'h01, 3'd0, 8'h11, 3'd0, 1'b1};
    tbl[1] = '{2'd0, 1'b1, 3'd5, 8'h22, 8'hFF, 1'b1, 8'h20, 3'd5, 8'h22, 3'd0, 1'b1};
    tbl[2] = '{2'd0, 1'b1, 3'd7, 8'h33, 8'hFF, 1'b1, 8'h80, 3'd7, 8'h33, 3'd0, 1'b1};
    for (int i = 0; i < 9; i++)
      tbl[3+i] = '{2'd1, 1'b1, 3'(7 - (i % 8)), 8'(8'hA0 + i), 8'hFF, 1'b1,
                   8'(1 << (i % 8)), 3'(i % 8), 8'(8'hA0 + i), 3'((i + 1) % 8), 1'b1};
    tbl[12] = '{2'd0, 1'b0, 3'd3, 8'h00, 8'hFF, 1'b1, 8'h00, 3'd0, 8'h00, 3'd1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      drive8(tbl[i].mode, tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), bus8.in_ready, tbl[i].exp_rdy);
      post_edge();
      chk($sformatf("tbl%0d_out_valid", i), bus8.out_valid, tbl[i].exp_ov);
      if (tbl[i].chk_d) chk($sformatf("tbl%0d_out_data", i), d8(tbl[i].chk_ch), tbl[i].exp_d);
      chk($sformatf("tbl%0d_rr_ptr", i), bus8.rr_ptr, tbl[i].exp_ptr);
    end

    // Broadcast blocked by a full, stalled channel 3.
    drive8(DIRECT, 1'b1, 3'd3, 8'h33, 8'hF7);
    post_edge();
    chk("bc_fill_ch3", bus8.out_valid, 64'h08);
    for (int c = 0; c < 2; c++) begin
      drive8(BROADCAST, 1'b1, 3'd0, 8'h5A, 8'hF7);
      #1;
      chk("bc_blocked_in_ready", bus8.in_ready, 64'h0);
      post_edge();
      chk("bc_blocked_out_valid", bus8.out_valid, 64'h08);
      chk("bc_blocked_ch3_data", d8(3), 64'h33);
    end
    drive8(BROADCAST, 1'b1, 3'd0, 8'h5A, 8'hFF);
    #1;
    chk("bc_open_in_ready", bus8.in_ready, 64'h1);
    post_edge();
    chk("bc_out_valid", bus8.out_valid, 64'hFF);
    for (int k = 0; k < 8; k++) chk($sformatf("bc_ch%0d_data", k), d8(k), 64'h5A);
    chk("bc_rr_ptr_kept", bus8.rr_ptr, 64'h1);
    drive8(DIRECT, 1'b0, 3'd0, 8'h00, 8'hFF);
    post_edge();
    chk("bc_drain", bus8.out_valid, 64'h0);

    // Channel 2 stalled for five cycles.
    drive8(DIRECT, 1'b1, 3'd2, 8'h42, 8'hFB);
    post_edge();
    chk("stall_load", bus8.out_valid, 64'h04);
    for (int c = 0; c < 5; c++) begin
      drive8(DIRECT, 1'b0, 3'd2, 8'h99, 8'hFB);
      #1;
      chk("stall_rdy_sel2", bus8.in_ready, 64'h0);
      bus8.in_sel = 3'd4;
      #1;
      chk("stall_rdy_sel4", bus8.in_ready, 64'h1);
      post_edge();
      chk("stall_ch2_data", d8(2), 64'h42);
      chk("stall_ch2_valid", bus8.out_valid, 64'h04);
    end
    drive8(DIRECT, 1'b0, 3'd0, 8'h00, 8'hFF);
    post_edge();
    chk("stall_release", bus8.out_valid, 64'h0);

    // Out-of-range select on the 6-channel instance.
    drive6(DIRECT, 1'b1, 3'd7, 8'hFF, 1'b0);
    #1;
    chk("oob7_in_ready", bus6.in_ready, 64'h1);
    post_edge();
    chk("oob7_no_load", bus6.out_valid, 64'h0);
    chk("oob7_sel_err", bus6.sel_err, 64'h1);
    drive6(DIRECT, 1'b0, 3'd0, 8'h00, 1'b0);
    post_edge();
    chk("err_sticky", bus6.sel_err, 64'h1);
    drive6(DIRECT, 1'b0, 3'd0, 8'h00, 1'b1);
    post_edge();
    chk("err_clear", bus6.sel_err, 64'h0);
    drive6(RSVD, 1'b1, 3'd6, 8'h77, 1'b1);
    #1;
    chk("oob6_in_ready", bus6.in_ready, 64'h1);
    post_edge();
    chk("err_clr_collide", bus6.sel_err, 64'h1);
    chk("oob6_no_load", bus6.out_valid, 64'h0);
    drive6(DIRECT, 1'b0, 3'd0, 8'h00, 1'b1);
    post_edge();
    chk("err_clear2", bus6.sel_err, 64'h0);
    drive6(DIRECT, 1'b1, 3'd7, 8'h01, 1'b0);
    post_edge();
    chk("err_rearm", bus6.sel_err, 64'h1);
    drive6(DIRECT, 1'b0, 3'd0, 8'h00, 1'b0);

    // Reset asserted mid-stream with three channels held.
    for (int i = 0; i < 3; i++) begin
      drive8(ROUND_ROBIN, 1'b1, 3'd0, 8'(8'hC0 + i), 8'h00);
      post_edge();
    end
    chk("pre_rst_out_valid", bus8.out_valid, 64'h0E);
    chk("pre_rst_rr_ptr", bus8.rr_ptr, 64'h4);
    drive8(ROUND_ROBIN, 1'b0, 3'd0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus8.out_valid, 64'h0);
    chk("async_rst_out_data", bus8.out_data, 64'h0);
    chk("async_rst_rr_ptr", bus8.rr_ptr, 64'h0);
    chk("async_rst_sel_err", bus6.sel_err, 64'h0);
    do_reset();

    // Randomized traffic on the 6-channel instance against the model.
    for (int k = 0; k < 6; k++) begin m_vld[k] = 1'b0; m_dat[k] = '0; end
    m_ptr = 0;
    m_err = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int       md;
      int       sel;
      bit       vld;
      bit       clr;
      bit [7:0] dat;
      bit [5:0] ordy;
      bit       exp_rdy;
      bit       new_err;
      bit [5:0] exp_ov;

      md   = $urandom_range(0, 3);
      sel  = $urandom_range(0, 7);
      vld  = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      dat  = 8'($urandom);
      for (int k = 0; k < 6; k++) ordy[k] = ($urandom_range(0, 3) != 0);

      @(negedge clk);
      bus6.mode = 2'(md); bus6.in_sel = 3'(sel); bus6.in_valid = vld;
      bus6.in_data = dat; bus6.clr_err = clr; bus6.out_ready = ordy;

      if (md == 1)      exp_rdy = !m_vld[m_ptr] || ordy[m_ptr];
      else if (md == 2) begin
        exp_rdy = 1'b1;
        for (int k = 0; k < 6; k++) if (m_vld[k] && !ordy[k]) exp_rdy = 1'b0;
      end
      else if (sel >= 6) exp_rdy = 1'b1;
      else               exp_rdy = !m_vld[sel] || ordy[sel];

      for (int k = 0; k < 6; k++) if (m_vld[k] && ordy[k]) m_vld[k] = 1'b0;
      new_err = 1'b0;
      if (vld && exp_rdy) begin
        if (md == 1) begin
          m_vld[m_ptr] = 1'b1; m_dat[m_ptr] = dat; m_ptr = (m_ptr + 1) % 6;
        end else if (md == 2) begin
          for (int k = 0; k < 6; k++) begin m_vld[k] = 1'b1; m_dat[k] = dat; end
        end else if (sel < 6) begin
          m_vld[sel] = 1'b1; m_dat[sel] = dat;
        end else begin
          new_err = 1'b1;
        end
      end
      if (new_err)  m_err = 1'b1;
      else if (clr) m_err = 1'b0;

      #1;
      chk($sformatf("rnd%0d_in_ready", cyc), bus6.in_ready, exp_rdy);
      post_edge();
      for (int k = 0; k < 6; k++) exp_ov[k] = m_vld[k];
      chk($sformatf("rnd%0d_out_valid", cyc), bus6.out_valid, exp_ov);
      for (int k = 0; k < 6; k++)
        if (m_vld[k]) chk($sformatf("rnd%0d_ch%0d_data", cyc, k), d6(k), m_dat[k]);
      chk($sformatf("rnd%0d_rr_ptr", cyc), bus6.rr_ptr, m_ptr);
      chk($sformatf("rnd%0d_sel_err", cyc), bus6.sel_err, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter N_CH, default 8, number of output channels (2..16).
REQ-002 Parameter DW, default 8, data width in bits.
REQ-003 Localparam SELW = max(1, clog2(N_CH)), select width.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream data valid.
REQ-007 in_ready  output  1  upstream accept; transfer when in_valid & in_ready.
REQ-008 in_data  input  DW  upstream payload.
REQ-009 in_sel  input  SELW  target channel in DIRECT mode.
REQ-010 mode  input  2  00 DIRECT, 01 ROUND_ROBIN, 10 BROADCAST, 11 reserved.
REQ-011 out_valid  output  N_CH  per-channel valid.
REQ-012 out_ready  input  N_CH  per-channel downstream ready.
REQ-013 out_data  output  N_CH*DW  channel k at bits [k*DW +: DW].
REQ-014 sel_err  output  1  sticky out-of-range select flag.
REQ-015 clr_err  input  1  synchronous clear of sel_err.
REQ-016 rr_ptr  output  SELW  current round-robin target.

Function
REQ-017 Each channel SHALL hold a one-entry register (valid, data); channel k is "open" when !out_valid[k] | out_ready[k].
REQ-018 DIRECT: in_ready SHALL equal open[in_sel]; on transfer, channel in_sel loads in_data.
REQ-019 ROUND_ROBIN: in_sel ignored; in_ready SHALL equal open[rr_ptr]; on transfer, channel rr_ptr loads, rr_ptr increments, wrapping N_CH-1 -> 0.
REQ-020 BROADCAST: in_ready SHALL equal AND of open over all channels; on transfer, every channel loads in_data.
REQ-021 mode 11 SHALL behave as DIRECT.
REQ-022 Latency: in_data SHALL appear on out_data with out_valid high the cycle after transfer.
REQ-023 A channel SHALL drop out_valid the cycle after out_valid & out_ready unless reloaded in that same cycle; simultaneous pop and push SHALL sustain one word per cycle.
REQ-024 out_data of a channel SHALL hold stable while out_valid & !out_ready.
REQ-025 DIRECT with in_sel >= N_CH: in_ready SHALL be 1, word dropped, no channel loaded, sel_err set next cycle.
REQ-026 sel_err SHALL stay set until clr_err; clr_err and a new error in the same cycle leave sel_err = 1.
REQ-027 rr_ptr SHALL change only on ROUND_ROBIN transfers; mode changes SHALL not alter rr_ptr.
REQ-028 in_ready SHALL depend combinationally on mode, in_sel, out_valid, out_ready only, never on in_valid.

Reset
REQ-029 On rst_n low: out_valid = 0, out_data = 0, rr_ptr = 0, sel_err = 0, immediately and asynchronously.
REQ-030 Words held at reset assertion SHALL be discarded; reset release SHALL be synchronised to clk before state leaves reset values.

Structure
REQ-031 Package demux_pkg SHALL hold the mode enum (DIRECT, ROUND_ROBIN, BROADCAST, RSVD) and the N_CH bound constant.
REQ-032 Sub-module demux_ch_reg SHALL implement one channel register (load, data, out_ready -> out_valid, out_data), instantiated N_CH times by generate.

Verification
REQ-033 DIRECT, all out_ready=1, send 0x11,0x22,0x33 to sel 0,5,7 on consecutive cycles -> each appears on its channel one cycle later, one word/cycle.
REQ-034 ROUND_ROBIN, 9 words 0xA0..0xA8, all ready -> channels 0..7 get 0xA0..0xA7, channel 0 gets 0xA8, rr_ptr = 1 after.
REQ-035 BROADCAST 0x5A with out_ready[3]=0 and channel 3 full -> in_ready = 0 until out_ready[3]=1, then all 8 channels show 0x5A next cycle.
REQ-036 N_CH=6, DIRECT in_sel=7 with 0xFF -> in_ready=1, no out_valid change, sel_err=1 next cycle; clr_err pulse -> sel_err=0.
REQ-037 Channel 2 stalled (out_ready[2]=0) holding 0x42 for 5 cycles -> out_data[2] stays 0x42, in_ready=0 for in_sel=2, 1 for in_sel=4.
REQ-038 rst_n low mid-stream with 3 channels valid -> all out_valid=0, rr_ptr=0, sel_err=0 without a clock edge.
